fetch_pc_ctrl: RTL
==================

// Module: fetch_pc_ctrl
// PURPOSE
//   Sequences the fetch PC for the IF stage: selects the next fetch address from boot PC, BPU prediction,
//   DC-stage redirect and EXE mispredict; holds on stall/backpressure; tags fetches with a redirect epoch.
//   Sits between the BPU, the IM request port and the IF skid buffer. It owns the PC register and the
//   in-flight fetch count.
// PARAMETERS
//   RESET_PC        32'h2000  fetch address after reset
//   EPOCH_W         2         width of redirect epoch tag
//   MAX_OUTSTANDING 2         max fetches issued but not yet returned (1..7)
// PORTS
//   clk              in   1   clock
//   rst              in   1   synchronous active-high reset
//   bpu_pred_pc      in   32  BPU predicted target for fetch_pc (combinational from fetch_pc)
//   bpu_pred_taken   in   1   BPU predicts taken for fetch_pc
//   exe_redirect     in   1   EXE mispredict, highest priority
//   exe_redirect_pc  in   32  EXE correct target
//   dc_redirect      in   1   DC-stage redirect
//   dc_redirect_pc   in   32  DC redirect target
//   stall            in   1   pipeline stall from IS stage
//   im_ready         in   1   IF skid buffer can accept a fetch
//   rsp_valid        in   1   one fetch response consumed by DC this cycle
//   fetch_pc         out  32  IM read address / BPU lookup PC
//   fetch_req        out  1   fetch issued when fetch_req && im_ready
//   fetch_epoch      out  EPOCH_W  epoch tag travelling with this fetch
//   fetch_pred_taken out  1   BPU taken bit registered with this fetch
//   flush_if         out  1   kill IF/DC contents (combinational, = exe_redirect || dc_redirect)
//   redirect_cnt     out  32  accepted redirects (perf; see CONFIGURATION)
//   stall_cnt        out  32  cycles in HOLD (perf; see CONFIGURATION)
// BEHAVIOUR
//   Reset: pc_q=RESET_PC, epoch=0, outstanding=0, state=BOOT, fetch_pred_taken=0, counters=0.
//   States: BOOT (1 cycle, fetch_req=0) -> RUN. RUN -> HOLD when stall or outstanding==MAX_OUTSTANDING;
//     HOLD -> RUN when both clear. Any redirect from HOLD returns to RUN only once stall/full clear.
//   fetch_pc = exe_redirect ? exe_redirect_pc : dc_redirect ? dc_redirect_pc : pc_q (exe beats dc).
//   fetch_req = (state!=BOOT) && !stall && (outstanding<MAX_OUTSTANDING).
//   fire = fetch_req && im_ready. On fire: pc_q <= bpu_pred_taken ? bpu_pred_pc : fetch_pc+32'd4
//     (modulo 2^32, 32'hFFFF_FFFC+4 wraps to 0); fetch_pred_taken <= bpu_pred_taken.
//   Redirect without fire: pc_q <= selected redirect target (remembered across stall).
//   No redirect, no fire: pc_q holds.
//   Epoch: +1 (wrap mod 2^EPOCH_W) on every cycle with exe_redirect||dc_redirect (one step even if both);
//     fetch_epoch reflects the incremented value in the same cycle as the redirect.
//   Outstanding: +1 on fire, -1 on rsp_valid, unchanged if both; never cleared by redirect (stale
//     returns still consume slots; downstream drops by epoch). rsp_valid at 0 is ignored (saturate).
//   Reset asserted mid-operation: all state returns to reset values next edge; in-flight fetches discarded.
// CONFIGURATION
//   FETCH_PC_PERF_EN defined: redirect_cnt counts cycles with any redirect; stall_cnt counts HOLD cycles;
//     both 32-bit, wrap at 2^32, cleared by rst.
//   Not defined: redirect_cnt and stall_cnt tied to 32'd0; no counter flops.
// TESTING
//   Reset release, im_ready=1, no preds -> BOOT cycle fetch_req=0; then fetch_pc 0x2000,0x2004,0x2008.
//   bpu_pred_taken=1 pred 0x3000 at 0x2004 -> next fetch_pc 0x3000, fetch_pred_taken=1 with it.
//   exe_redirect 0x4000 + dc_redirect 0x5000 same cycle -> fetch_pc 0x4000, epoch +1 once, flush_if=1.
//   stall=1 with dc_redirect 0x6000 for 1 cycle, stall held 3 cycles -> fetch_req=0; first fetch after = 0x6000.
//   rsp_valid=0, im_ready=1, MAX_OUTSTANDING=2 -> 2 fires then fetch_req=0; one rsp_valid -> one more fire.
//   FETCH_PC_PERF_EN on: 3 redirects, 4 HOLD cycles -> redirect_cnt=3, stall_cnt=4; off -> both 0.

Source files
------------

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-side signal bundle between the PC sequencer and BPU / IM / pipeline control.
// master = PC sequencer, slave = surrounding fetch environment.
interface fetch_pc_ctrl_if #(
    parameter int EPOCH_W = 2
);
    logic [31:0]        bpu_pred_pc;
    logic               bpu_pred_taken;
    logic               exe_redirect;
    logic [31:0]        exe_redirect_pc;
    logic               dc_redirect;
    logic [31:0]        dc_redirect_pc;
    logic               stall;
    logic               im_ready;
    logic               rsp_valid;
    logic [31:0]        fetch_pc;
    logic               fetch_req;
    logic [EPOCH_W-1:0] fetch_epoch;
    logic               fetch_pred_taken;
    logic               flush_if;

    modport master (
        input  bpu_pred_pc, bpu_pred_taken,
        input  exe_redirect, exe_redirect_pc, dc_redirect, dc_redirect_pc,
        input  stall, im_ready, rsp_valid,
        output fetch_pc, fetch_req, fetch_epoch, fetch_pred_taken, flush_if
    );

    modport slave (
        output bpu_pred_pc, bpu_pred_taken,
        output exe_redirect, exe_redirect_pc, dc_redirect, dc_redirect_pc,
        output stall, im_ready, rsp_valid,
        input  fetch_pc, fetch_req, fetch_epoch, fetch_pred_taken, flush_if
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// IF-stage PC sequencer: redirect/prediction select is combinational (0-cycle), fetch held on stall or when
// MAX_OUTSTANDING fetches are in flight. Define FETCH_PC_PERF_EN to build the redirect/HOLD perf counters.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h2000,
    parameter int          EPOCH_W         = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_pc_ctrl_if.master       fif,
    output logic [31:0]           redirect_cnt,
    output logic [31:0]           stall_cnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [2:0] MAX_O = 3'(MAX_OUTSTANDING);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [2:0]         outst_q, outst_d;
    logic               pred_taken_q, pred_taken_d;

    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               full;
    logic               fire;
    logic               rsp_dec;
    logic [31:0]        fetch_pc;

    // EXE mispredict outranks the DC-stage redirect.
    assign redirect    = fif.exe_redirect || fif.dc_redirect;
    assign redirect_pc = fif.exe_redirect ? fif.exe_redirect_pc : fif.dc_redirect_pc;
    assign fetch_pc    = redirect ? redirect_pc : pc_q;
    assign full        = (outst_q >= MAX_O);
    assign fire        = fif.fetch_req && fif.im_ready;
    assign rsp_dec     = fif.rsp_valid && (outst_q != 3'd0);

    assign fif.fetch_pc         = fetch_pc;
    assign fif.fetch_req        = (state_q != S_BOOT) && !fif.stall && !full;
    assign fif.fetch_epoch      = epoch_d;
    assign fif.fetch_pred_taken = pred_taken_q;
    assign fif.flush_if         = redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (fif.stall || full) state_d = S_HOLD;
            S_HOLD:  if (!fif.stall && !full) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        pred_taken_d = pred_taken_q;
        outst_d      = outst_q;
        epoch_d      = epoch_q + EPOCH_W'(redirect);

        // A redirect that cannot issue this cycle is parked in pc_q until the stall clears.
        if (fire) begin
            pc_d         = fif.bpu_pred_taken ? fif.bpu_pred_pc : fetch_pc + 32'd4;
            pred_taken_d = fif.bpu_pred_taken;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end

        // Stale returns after a redirect still free their slot; epochs let downstream drop them.
        if (fire && !rsp_dec) begin
            outst_d = outst_q + 3'd1;
        end else if (!fire && rsp_dec) begin
            outst_d = outst_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            epoch_q      <= '0;
            outst_q      <= 3'd0;
            pred_taken_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epoch_q      <= epoch_d;
            outst_q      <= outst_d;
            pred_taken_q <= pred_taken_d;
        end
    end

`ifdef FETCH_PC_PERF_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            if (redirect) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if (state_q == S_HOLD) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`else
    assign redirect_cnt = 32'd0;
    assign stall_cnt    = 32'd0;
`endif

`ifndef SYNTHESIS
    a_outst_bound: assert property (@(posedge clk) disable iff (rst) outst_q <= MAX_O);
`endif

endmodule
